// File: rtl/lbp_pkg.sv
// Shared constants and types for the LBP host memory block.
package lbp_pkg;

  localparam int unsigned LBP_W    = 7;
  localparam int unsigned LBP_NPIX = 1 << (2 * LBP_W);

  typedef enum logic [1:0] {LOAD, RUN, DUMP, DONE} host_state_t;

  typedef logic [2*LBP_W-1:0] lbp_addr_t;

endpackage

// File: rtl/lbp_host_mem_if.sv
// Host-side bus bundle: image load, engine gray/LBP access, result stream.
interface lbp_host_mem_if
  import lbp_pkg::*;
#(
  parameter int unsigned W = LBP_W
) ();

  logic            load_valid;
  logic [7:0]      load_data;
  logic            gray_ready;
  logic            gray_req;
  logic [2*W-1:0]  gray_addr;
  logic [7:0]      gray_data;
  logic            lbp_valid;
  logic [2*W-1:0]  lbp_addr;
  logic [7:0]      lbp_data;
  logic            finish;
  logic            out_valid;
  logic            out_ready;
  logic [7:0]      out_data;
  logic            done;

  // Responder side (the host memory itself).
  modport slave (
    input  load_valid, load_data, gray_req, gray_addr,
           lbp_valid, lbp_addr, lbp_data, finish, out_ready,
    output gray_ready, gray_data, out_valid, out_data, done
  );

  // Driver side (loader, engine and result sink together).
  modport master (
    output load_valid, load_data, gray_req, gray_addr,
           lbp_valid, lbp_addr, lbp_data, finish, out_ready,
    input  gray_ready, gray_data, out_valid, out_data, done
  );

endinterface

// File: rtl/lbp_host_sram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Read data holds while re is low; reset clears only the read register.
module lbp_host_sram
  import lbp_pkg::*;
#(
  parameter int unsigned AW = 2 * LBP_W,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Array write, no reset so the contents survive a host reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/lbp_host_mem.sv
// Host responder for the LBP engine: gray RAM, LBP RAM, result dump.
// Optional build macro: LBP_HOST_BORDER_CLEAR_EN forces border pixels
// to zero in the dump stream.
module lbp_host_mem
  import lbp_pkg::*;
#(
  parameter int unsigned W = LBP_W
) (
  input  logic           clk,
  input  logic           reset,
  lbp_host_mem_if.slave  bus
);

  localparam int unsigned AW = 2 * W;
  localparam logic [AW-1:0] LAST = '1;

  host_state_t   state;
  logic [AW-1:0] load_cnt;
  logic [AW-1:0] dump_cnt;
  logic [AW-1:0] rd_cnt;
  logic          rd_all;
  logic          ram_vld;
  logic          gray_ready;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          done;
  logic [7:0]    gray_rdata;
  logic [7:0]    lbp_rdata;
  logic          gray_we, gray_re, lbp_we, lbp_re, advance, xfer;

  assign bus.gray_ready = gray_ready;
  assign bus.gray_data  = gray_rdata;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = out_data;
  assign bus.done       = done;

  // RAM port enables and dump pipeline advance, gated by state.
  always_comb begin
    gray_we = (state == LOAD) && bus.load_valid;
    gray_re = (state == RUN)  && bus.gray_req;
    lbp_we  = (state == RUN)  && bus.lbp_valid;
    advance = (state == DUMP) && (!out_valid || bus.out_ready);
    lbp_re  = advance && !rd_all;
    xfer    = (state == DUMP) && out_valid && bus.out_ready;
  end

  lbp_host_sram #(.AW(AW), .DW(8)) u_gray_ram (
    .clk   (clk),
    .reset (reset),
    .we    (gray_we),
    .waddr (load_cnt),
    .wdata (bus.load_data),
    .re    (gray_re),
    .raddr (bus.gray_addr),
    .rdata (gray_rdata)
  );

  lbp_host_sram #(.AW(AW), .DW(8)) u_lbp_ram (
    .clk   (clk),
    .reset (reset),
    .we    (lbp_we),
    .waddr (bus.lbp_addr),
    .wdata (bus.lbp_data),
    .re    (lbp_re),
    .raddr (rd_cnt),
    .rdata (lbp_rdata)
  );

`ifdef LBP_HOST_BORDER_CLEAR_EN
  logic ram_border;

  function automatic logic at_border(input logic [AW-1:0] a);
    logic [W-1:0] r;
    logic [W-1:0] c;
    r = a[AW-1:W];
    c = a[W-1:0];
    return (r == '0) || (r == '1) || (c == '0) || (c == '1);
  endfunction

  // Border tag travels alongside each LBP RAM read.
  always_ff @(posedge clk) begin
    if (reset)       ram_border <= 1'b0;
    else if (lbp_re) ram_border <= at_border(rd_cnt);
  end
`endif

  // Main FSM; the dump is a two-stage pipe (RAM read register feeding the
  // output register) that advances as one unit, so a stall freezes both
  // stages and transfers prefetch the next address without bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LOAD;
      load_cnt   <= '0;
      dump_cnt   <= '0;
      rd_cnt     <= '0;
      rd_all     <= 1'b0;
      ram_vld    <= 1'b0;
      gray_ready <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      done       <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (bus.load_valid) begin
            load_cnt <= load_cnt + 1'b1;
            if (load_cnt == LAST) begin
              state      <= RUN;
              gray_ready <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.finish) begin
            state      <= DUMP;
            gray_ready <= 1'b0;
            rd_cnt     <= '0;
            dump_cnt   <= '0;
            rd_all     <= 1'b0;
            ram_vld    <= 1'b0;
          end
        end
        DUMP: begin
          if (advance) begin
            out_valid <= ram_vld;
`ifdef LBP_HOST_BORDER_CLEAR_EN
            out_data  <= (ram_vld && !ram_border) ? lbp_rdata : '0;
`else
            out_data  <= ram_vld ? lbp_rdata : '0;
`endif
            ram_vld   <= !rd_all;
            if (!rd_all) begin
              rd_cnt <= rd_cnt + 1'b1;
              rd_all <= (rd_cnt == LAST);
            end
          end
          if (xfer) begin
            dump_cnt <= dump_cnt + 1'b1;
            if (dump_cnt == LAST) begin
              state     <= DONE;
              out_valid <= 1'b0;
              out_data  <= '0;
              done      <= 1'b1;
            end
          end
        end
        DONE: begin
          done <= 1'b1;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_lbp_host_mem.sv
// Directed bench for lbp_host_mem: load, engine access, dump, reset abort.
module tb_lbp_host_mem;
  import lbp_pkg::*;

  localparam int SIDE = 1 << LBP_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lbp_host_mem_if #(.W(LBP_W)) bus ();

  lbp_host_mem #(.W(LBP_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] lbp_model [LBP_NPIX];
  bit         lbp_known [LBP_NPIX];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.gray_req   = 1'b0;
    bus.gray_addr  = '0;
    bus.lbp_valid  = 1'b0;
    bus.lbp_addr   = '0;
    bus.lbp_data   = '0;
    bus.finish     = 1'b0;
    bus.out_ready  = 1'b0;
  endtask

  function automatic bit is_edge(input int a);
    int r, c;
    r = a / SIDE;
    c = a % SIDE;
    return (r == 0) || (r == SIDE - 1) || (c == 0) || (c == SIDE - 1);
  endfunction

  function automatic bit exp_known(input int a);
`ifdef LBP_HOST_BORDER_CLEAR_EN
    if (is_edge(a)) return 1'b1;
`endif
    return lbp_known[a];
  endfunction

  function automatic logic [7:0] exp_pix(input int a);
`ifdef LBP_HOST_BORDER_CLEAR_EN
    if (is_edge(a)) return 8'h00;
`endif
    return lbp_model[a];
  endfunction

  // Raster load of (i+offs)&255 with occasional gaps; finish and gray_req
  // are pulsed inside the gaps and must have no effect in LOAD.
  task automatic load_image(input int offs);
    for (int i = 0; i < LBP_NPIX; i++) begin
      if (i % 5000 == 77) begin
        bus.load_valid = 1'b0;
        bus.finish     = 1'b1;
        bus.gray_req   = 1'b1;
        bus.gray_addr  = 14'd129;
        tick();
        bus.finish     = 1'b0;
        bus.gray_req   = 1'b0;
      end
      bus.load_valid = 1'b1;
      bus.load_data  = 8'((i + offs) & 255);
      tick();
      if (i == LBP_NPIX - 2) check_eq("gray_ready_early", 32'(bus.gray_ready), 32'd0);
    end
    bus.load_valid = 1'b0;
    check_eq("gray_ready_rise", 32'(bus.gray_ready), 32'd1);
    check_eq("gray_data_load_ignored", 32'(bus.gray_data), 32'd0);
  endtask

  task automatic gray_read(input string tag, input int addr, input logic [7:0] exp);
    bus.gray_req  = 1'b1;
    bus.gray_addr = 14'(addr);
    tick();
    bus.gray_req  = 1'b0;
    check_eq(tag, 32'(bus.gray_data), 32'(exp));
  endtask

  task automatic lbp_write(input int addr, input logic [7:0] data);
    bus.lbp_valid = 1'b1;
    bus.lbp_addr  = 14'(addr);
    bus.lbp_data  = data;
    lbp_model[addr] = data;
    lbp_known[addr] = 1'b1;
    tick();
    bus.lbp_valid = 1'b0;
  endtask

  initial begin
    int xfers;
    int cyc;
    bit stall_prev;
    logic [7:0] prev_data;
    bit [3:0] pat;

    pat = 4'b1001;
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    check_eq("rst_gray_ready", 32'(bus.gray_ready), 32'd0);
    check_eq("rst_gray_data",  32'(bus.gray_data),  32'd0);
    check_eq("rst_out_valid",  32'(bus.out_valid),  32'd0);
    check_eq("rst_out_data",   32'(bus.out_data),   32'd0);
    check_eq("rst_done",       32'(bus.done),       32'd0);
    reset = 1'b0;

    // ---- first run: load ramp, engine reads/writes, abort mid-dump ----
    load_image(0);
    bus.load_valid = 1'b1;
    bus.load_data  = 8'hEE;
    tick();
    bus.load_valid = 1'b0;

    gray_read("gray_rd_129", 129, 8'h81);
    tick();
    check_eq("gray_hold", 32'(bus.gray_data), 32'h81);
    gray_read("gray_rd_last", 16383, 8'hFF);
    gray_read("gray_rd_0_run_load_ignored", 0, 8'h00);

    // same-cycle write and read of address 130
    bus.gray_req  = 1'b1;
    bus.gray_addr = 14'd130;
    lbp_write(130, 8'h5A);
    bus.gray_req  = 1'b0;
    check_eq("gray_rd_130_with_wr", 32'(bus.gray_data), 32'h82);

    // finish together with a write; 131 is left untouched by the second run
    bus.finish = 1'b1;
    lbp_write(131, 8'hC3);
    bus.finish = 1'b0;
    check_eq("gray_ready_fall", 32'(bus.gray_ready), 32'd0);
    tick();
    check_eq("dump1_valid_n1", 32'(bus.out_valid), 32'd0);
    tick();
    check_eq("dump1_valid_n2", 32'(bus.out_valid), 32'd1);
    tick();
    check_eq("dump1_stalled", 32'(bus.out_valid), 32'd1);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("abort_out_valid",  32'(bus.out_valid),  32'd0);
    check_eq("abort_gray_ready", 32'(bus.gray_ready), 32'd0);
    check_eq("abort_out_data",   32'(bus.out_data),   32'd0);
    check_eq("abort_done",       32'(bus.done),       32'd0);

    // ---- second run: fresh load required, full dump with back-pressure ----
    load_image(3);
    gray_read("gray2_rd_129", 129, 8'h84);

    for (int k = 0; k < 300; k++) begin
      if (k != 131) lbp_write(k, 8'((k * 7 + 3) & 255));
    end
    lbp_write(16256, 8'h33);
    lbp_write(16383, 8'h44);
    bus.gray_req  = 1'b1;
    bus.gray_addr = 14'd130;
    lbp_write(130, 8'h5A);
    bus.gray_req  = 1'b0;
    check_eq("gray2_rd_130_with_wr", 32'(bus.gray_data), 32'h85);

    bus.finish = 1'b1;
    lbp_write(200, 8'hA7);
    bus.finish = 1'b0;
    check_eq("gray2_ready_fall", 32'(bus.gray_ready), 32'd0);
    tick();
    check_eq("dump2_valid_n1", 32'(bus.out_valid), 32'd0);
    tick();
    check_eq("dump2_valid_n2", 32'(bus.out_valid), 32'd1);
    check_eq("dump2_first_data", 32'(bus.out_data), 32'(exp_pix(0)));

    xfers = 0;
    cyc = 0;
    stall_prev = 1'b0;
    prev_data = '0;
    while (xfers < LBP_NPIX && cyc < 40000) begin
      bus.out_ready = pat[cyc % 4];
      if (stall_prev) begin
        check_eq("stall_data_hold",  32'(bus.out_data),  32'(prev_data));
        check_eq("stall_valid_hold", 32'(bus.out_valid), 32'd1);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_known(xfers))
          check_eq($sformatf("dump_pix_%0d", xfers), 32'(bus.out_data), 32'(exp_pix(xfers)));
        if (xfers == 8000) check_eq("done_mid_dump", 32'(bus.done), 32'd0);
        xfers++;
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      tick();
      cyc++;
    end
    bus.out_ready = 1'b0;
    check_eq("dump_count", 32'(xfers), 32'(LBP_NPIX));
    check_eq("done_rise", 32'(bus.done), 32'd1);
    check_eq("done_out_valid", 32'(bus.out_valid), 32'd0);
    tick();
    tick();
    check_eq("done_sticky", 32'(bus.done), 32'd1);
    check_eq("done_gray_ready", 32'(bus.gray_ready), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
